// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the CPU MEM stage and one
// external requester. The CPU has priority; a starvation limit guarantees the external side a grant.
module dmem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_LIM = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_done,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int SC_W  = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic {OWN_CPU, OWN_EXT} owner_t;

    state_t             state, state_nxt;
    owner_t             owner, owner_nxt;
    logic [LAT_W-1:0]   lat_cnt, lat_cnt_nxt;
    logic [SC_W-1:0]    starve_cnt;
    logic               cpu_req;
    logic               starve_full;
    logic               gnt_cpu;
    logic               gnt_ext;
    logic               capture;

    assign cpu_req     = cpu_re | cpu_we;
    assign starve_full = (starve_cnt == SC_W'(STARVE_LIM));
    assign capture     = (state == WAIT) && (lat_cnt == LAT_W'(MEM_LAT));

    always_comb begin
        // NOTE: everything written here gets a default first, so no path can infer a latch.
        state_nxt   = state;
        owner_nxt   = owner;
        lat_cnt_nxt = lat_cnt;
        gnt_cpu     = 1'b0;
        gnt_ext     = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        ext_gnt     = 1'b0;
        ext_done    = 1'b0;
        cpu_stall   = 1'b0;
        // Every combinational output stays low while reset is asserted.
        if (rst) begin
            unique case (state)
                IDLE: begin
                    if (cpu_req && !(ext_req && starve_full)) begin
                        gnt_cpu = 1'b1;
                    end else if (ext_req) begin
                        gnt_ext = 1'b1;
                    end
                    if (gnt_cpu) begin
                        mem_en    = 1'b1;
                        mem_we    = cpu_we;
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                    end else if (gnt_ext) begin
                        mem_en    = 1'b1;
                        mem_we    = ext_we;
                        mem_addr  = ext_addr;
                        mem_wdata = ext_wdata;
                        ext_gnt   = 1'b1;
                        ext_done  = ext_we;
                    end
                    // Writes finish in the issue cycle; only reads enter the wait phase.
                    if (mem_en && !mem_we) begin
                        state_nxt   = WAIT;
                        owner_nxt   = gnt_ext ? OWN_EXT : OWN_CPU;
                        lat_cnt_nxt = LAT_W'(1);
                    end
                    cpu_stall = cpu_req && !(gnt_cpu && cpu_we);
                end
                WAIT: begin
                    cpu_stall = cpu_req;
                    if (capture) begin
                        state_nxt   = RESP;
                        lat_cnt_nxt = '0;
                    end else begin
                        lat_cnt_nxt = lat_cnt + LAT_W'(1);
                    end
                end
                RESP: begin
                    state_nxt = IDLE;
                    cpu_stall = cpu_req && (owner != OWN_CPU);
                    ext_done  = (owner == OWN_EXT);
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: state registers use non-blocking assignment so all update together at the edge.
            state   <= IDLE;
            owner   <= OWN_CPU;
            lat_cnt <= '0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            lat_cnt <= lat_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!ext_req || gnt_ext) begin
            starve_cnt <= '0;
        end else if (gnt_cpu && !starve_full) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    // Read data is only ever registered, so mem_rdata has no path to an output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rdata <= '0;
            ext_rdata <= '0;
        end else if (capture) begin
            if (owner == OWN_CPU) begin
                cpu_rdata <= mem_rdata;
            end else begin
                ext_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences the single data-memory port fed by the MEM stage of the CPU pipeline, downstream of the EX/MEM register.
- Shares that port with one external requester, such as a DMA or host debug port.
- Stalls the pipeline for multi-cycle reads.
- Gives the CPU priority, with a starvation limit that guarantees the external requester a grant.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from read issue to valid mem_rdata (>=1)
STARVE_LIM, 3, consecutive CPU grants allowed while ext_req is pending

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
cpu_re  in  1  MEM-stage load request
cpu_we  in  1  MEM-stage store request (if both cpu_re and cpu_we are 1, treated as a store)
cpu_addr  in  ADDR_W  CPU address, stable while cpu_stall=1
cpu_wdata  in  DATA_W  CPU store data
cpu_stall  out  1  freezes the pipeline registers
cpu_rdata  out  DATA_W  registered load data
ext_req  in  1  external request, held until ext_done
ext_we  in  1  external write (1) / read (0)
ext_addr  in  ADDR_W  external address
ext_wdata  in  DATA_W  external write data
ext_gnt  out  1  pulse in the issue cycle
ext_done  out  1  pulse at completion
ext_rdata  out  DATA_W  registered external read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after issue

Behaviour:
- States: IDLE, WAIT, RESP. Registers: state, owner (CPU/EXT), lat_cnt, starve_cnt, cpu_rdata, ext_rdata.
- Reset (rst=0): state=IDLE, starve_cnt=0, lat_cnt=0, cpu_rdata=0, ext_rdata=0. All outputs are 0 while reset is held.
- Issue occurs only in IDLE, combinationally, in the cycle a request is seen.
  - mem_en=1; mem_we, mem_addr and mem_wdata are muxed from the winner.
  - When no issue occurs: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Arbitration when both cpu_req (cpu_re|cpu_we) and ext_req are high: CPU wins unless starve_cnt==STARVE_LIM, in which case EXT wins.
- starve_cnt:
  - +1 on each CPU grant made while ext_req=1, saturating at STARVE_LIM.
  - Cleared on an EXT grant, or in any cycle where ext_req=0.
- Writes complete in the issue cycle.
  - CPU write: cpu_stall=0 in that cycle (zero-stall store).
  - EXT write: ext_gnt=1 and ext_done=1 in the same cycle.
  - State remains IDLE.
- Read at issue cycle T:
  - Owner is latched; state goes to WAIT; lat_cnt=1.
  - WAIT increments lat_cnt each cycle. In cycle T+MEM_LAT, mem_rdata is captured into the owner's rdata register and the state goes to RESP.
  - RESP (cycle T+MEM_LAT+1): CPU owner gives cpu_stall=0; EXT owner gives ext_done=1. Next state is IDLE.
  - No issue is made in WAIT or RESP.
- cpu_stall = cpu_req & ~(CPU write issued this cycle | RESP with owner=CPU), gated low during reset.
  - A CPU read therefore stalls for MEM_LAT+1 cycles.
  - A CPU request blocked by an EXT transaction stalls until its own completion.
- ext_gnt is high only in the issue cycle.
- If ext_req drops mid-read, the transaction still completes and ext_done still pulses.
- cpu_rdata and ext_rdata hold their value until the next capture.
- Reset mid-transaction returns to IDLE immediately. Any late mem_rdata is discarded and never captured.
- lat_cnt width is clog2(MEM_LAT+1).
- No combinational path from mem_rdata to any output.

Test Plan:
1. Hold rst=0 with cpu_re=1 and ext_req=1, then release -> while held, every output is 0. After release, the first cycle issues the CPU access (mem_en=1).
2. CPU store, addr 0x0010, data 0xDEADBEEF, in IDLE -> in the same cycle mem_en=1, mem_we=1, mem_addr=0x0010, mem_wdata=0xDEADBEEF, cpu_stall=0.
3. CPU load at T, addr 0x0020; memory drives 0x12345678 at T+2 -> cpu_stall=1 at T, T+1, T+2. At T+3: cpu_stall=0 and cpu_rdata=0x12345678. mem_en=1 only at T.
4. Continuous back-to-back CPU loads with ext_req=1 (read, addr 0x0100) -> three CPU grants, then the fourth grant goes to EXT (ext_gnt=1). ext_done=1 with ext_rdata valid 3 cycles after ext_gnt. starve_cnt returns to 0.
5. EXT write, addr 0x0200, data 0xA5A5A5A5, with CPU idle -> ext_gnt=1 and ext_done=1 in the same cycle; mem_we=1. A CPU store the next cycle issues with no stall.
6. CPU load issued at T; rst=0 at T+1; released at T+2; memory drives 0xCAFEF00D at T+2 -> state IDLE and cpu_stall=0 during reset. cpu_rdata stays 0.
